// File: rtl/time_set_ctrl_pkg.sv
// Shared definitions for the time-set control stage: mode encodings,
// step-output indices and small helpers used to size counters.
package time_set_ctrl_pkg;

    localparam int unsigned MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        MODE_RUN      = 3'd0,
        MODE_SET_HR   = 3'd1,
        MODE_SET_MIN  = 3'd2,
        MODE_SET_AHR  = 3'd3,
        MODE_SET_AMIN = 3'd4
    } mode_e;

    // Bit positions inside the step vector, one per downstream counter
    localparam int unsigned STEP_HR   = 0;
    localparam int unsigned STEP_MIN  = 1;
    localparam int unsigned STEP_AHR  = 2;
    localparam int unsigned STEP_AMIN = 3;

    // MODE button cycles through the set modes and back to RUN
    function automatic mode_e next_mode(input mode_e m);
        case (m)
            MODE_RUN:      return MODE_SET_HR;
            MODE_SET_HR:   return MODE_SET_MIN;
            MODE_SET_MIN:  return MODE_SET_AHR;
            MODE_SET_AHR:  return MODE_SET_AMIN;
            default:       return MODE_RUN;
        endcase
    endfunction

    // Bits needed to hold 0..n_states-1 (never less than one bit)
    function automatic int unsigned cnt_w(input int unsigned n_states);
        if (n_states > 1) return $clog2(n_states);
        return 1;
    endfunction

endpackage

// File: rtl/time_set_ctrl_btn_conditioner.sv
// Front-panel button conditioner: two-flop synchroniser, debounce counter
// and single-cycle press pulse on a rising edge of the accepted level.
//   clk_i   : system clock
//   rst_i   : asynchronous reset, active-high
//   btn_i   : raw asynchronous button input, active-high
//   level_o : debounced (accepted) button level
//   press_o : one-cycle pulse, issued in the cycle the accepted level rises
module btn_conditioner
    import time_set_ctrl_pkg::*;
#(
    parameter int unsigned DEB_CYC = 500_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic level_o,
    output logic press_o
);

    localparam int unsigned CW = cnt_w(DEB_CYC);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count consecutive cycles where the synchronised input disagrees with
    // the accepted level; the DEB_CYC-th such cycle flips the level.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEB_CYC - 1)) begin
                level_d = ~level_q;
                press_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Time-set control stage feeding the digit counters: conditions MODE/INC,
// derives the 1 Hz seconds tick, runs the set-mode FSM with INC auto-repeat
// and idle timeout, and emits single-cycle strobes to the counters.
//   Clk, Clr      : clock, asynchronous active-high reset
//   btn_mode/inc  : raw front-panel buttons
//   sec_tick      : seconds enable (RUN only)
//   sec_clr_n     : active-low seconds clear on SET_HR -> SET_MIN
//   *_step        : one-cycle Up/Enable to the time/alarm hour/minute counters
//   mode          : current mode encoding
//   blink         : display blank strobe for the field being set
module time_set_ctrl
    import time_set_ctrl_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned DEB_CYC   = 500_000,
    parameter int unsigned REP_DLY   = 25_000_000,
    parameter int unsigned REP_PER   = 6_250_000,
    parameter int unsigned TIMEOUT_S = 30
) (
    input  logic              Clk,
    input  logic              Clr,
    input  logic              btn_mode,
    input  logic              btn_inc,
    output logic              sec_tick,
    output logic              sec_clr_n,
    output logic              hour_step,
    output logic              min_step,
    output logic              alm_hour_step,
    output logic              alm_min_step,
    output logic [MODE_W-1:0] mode,
    output logic              blink
);

    localparam int unsigned PW = cnt_w(CLK_HZ);
    localparam int unsigned RW = cnt_w((REP_DLY > REP_PER) ? REP_DLY : REP_PER);
    localparam int unsigned IW = cnt_w(TIMEOUT_S);

    logic mode_press, mode_level_unused;
    logic inc_press, inc_level;

    btn_conditioner #(.DEB_CYC(DEB_CYC)) u_btn_mode (
        .clk_i   (Clk),
        .rst_i   (Clr),
        .btn_i   (btn_mode),
        .level_o (mode_level_unused),
        .press_o (mode_press)
    );

    btn_conditioner #(.DEB_CYC(DEB_CYC)) u_btn_inc (
        .clk_i   (Clk),
        .rst_i   (Clr),
        .btn_i   (btn_inc),
        .level_o (inc_level),
        .press_o (inc_press)
    );

    logic [PW-1:0] presc_q, presc_d;
    mode_e         mode_q, mode_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          rep_active_q, rep_active_d;
    logic          rep_per_q, rep_per_d;
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic [3:0]    step_q, step_d;
    logic          sec_tick_q, sec_tick_d;
    logic          sec_clr_n_q, sec_clr_n_d;
    logic          blink_q, blink_d;

    logic          tick1, setm, fire_press, fire_rep, fire;
    logic [RW-1:0] rep_lim;

    always_comb begin
        tick1   = (presc_q == PW'(CLK_HZ - 1));
        presc_d = tick1 ? '0 : presc_q + 1'b1;
        setm    = (mode_q != MODE_RUN);

        // Repeat timer restarts on every step; first interval is REP_DLY,
        // later ones REP_PER. A MODE press in the same cycle wins over INC.
        rep_lim    = rep_per_q ? RW'(REP_PER - 1) : RW'(REP_DLY - 1);
        fire_press = setm & inc_press & ~mode_press;
        fire_rep   = setm & rep_active_q & inc_level & ~mode_press & (rep_cnt_q == rep_lim);
        fire       = fire_press | fire_rep;

        if (fire_press) begin
            rep_active_d = 1'b1;
        end else if (~inc_level | mode_press | ~setm) begin
            rep_active_d = 1'b0;
        end else begin
            rep_active_d = rep_active_q;
        end

        rep_cnt_d = (fire | ~rep_active_d) ? '0 : rep_cnt_q + 1'b1;

        if (fire_press) begin
            rep_per_d = 1'b0;
        end else if (fire_rep) begin
            rep_per_d = 1'b1;
        end else begin
            rep_per_d = rep_per_q;
        end

        step_d = '0;
        if (fire) begin
            case (mode_q)
                MODE_SET_HR:   step_d[STEP_HR]   = 1'b1;
                MODE_SET_MIN:  step_d[STEP_MIN]  = 1'b1;
                MODE_SET_AHR:  step_d[STEP_AHR]  = 1'b1;
                MODE_SET_AMIN: step_d[STEP_AMIN] = 1'b1;
                default:       step_d = '0;
            endcase
        end

        mode_d = mode_q;
        idle_d = idle_q;
        if (mode_press) begin
            mode_d = next_mode(mode_q);
            idle_d = '0;
        end else if (~setm | inc_press) begin
            idle_d = '0;
        end else if (tick1) begin
            if (idle_q == IW'(TIMEOUT_S - 1)) begin
                mode_d = MODE_RUN;
                idle_d = '0;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end

        sec_tick_d  = tick1 & ~setm;
        sec_clr_n_d = ~((mode_q == MODE_SET_HR) && (mode_d == MODE_SET_MIN));
        blink_d     = setm && (presc_q < PW'(CLK_HZ / 2));
    end

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            presc_q      <= '0;
            mode_q       <= MODE_RUN;
            idle_q       <= '0;
            rep_active_q <= 1'b0;
            rep_per_q    <= 1'b0;
            rep_cnt_q    <= '0;
            step_q       <= '0;
            sec_tick_q   <= 1'b0;
            sec_clr_n_q  <= 1'b1;
            blink_q      <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            mode_q       <= mode_d;
            idle_q       <= idle_d;
            rep_active_q <= rep_active_d;
            rep_per_q    <= rep_per_d;
            rep_cnt_q    <= rep_cnt_d;
            step_q       <= step_d;
            sec_tick_q   <= sec_tick_d;
            sec_clr_n_q  <= sec_clr_n_d;
            blink_q      <= blink_d;
        end
    end

    assign sec_tick      = sec_tick_q;
    assign sec_clr_n     = sec_clr_n_q;
    assign hour_step     = step_q[STEP_HR];
    assign min_step      = step_q[STEP_MIN];
    assign alm_hour_step = step_q[STEP_AHR];
    assign alm_min_step  = step_q[STEP_AMIN];
    assign mode          = mode_q;
    assign blink         = blink_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
module tb_time_set_ctrl;

    localparam int CLK_HZ    = 16;
    localparam int DEB_CYC   = 2;
    localparam int REP_DLY   = 8;
    localparam int REP_PER   = 4;
    localparam int TIMEOUT_S = 3;

    logic       Clk = 1'b0;
    logic       Clr = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic       sec_tick, sec_clr_n, hour_step, min_step, alm_hour_step, alm_min_step, blink;
    logic [2:0] mode;

    int vectors = 0;
    int errors  = 0;
    bit chk_en  = 1'b0;

    time_set_ctrl #(
        .CLK_HZ    (CLK_HZ),
        .DEB_CYC   (DEB_CYC),
        .REP_DLY   (REP_DLY),
        .REP_PER   (REP_PER),
        .TIMEOUT_S (TIMEOUT_S)
    ) dut (
        .Clk           (Clk),
        .Clr           (Clr),
        .btn_mode      (btn_mode),
        .btn_inc       (btn_inc),
        .sec_tick      (sec_tick),
        .sec_clr_n     (sec_clr_n),
        .hour_step     (hour_step),
        .min_step      (min_step),
        .alm_hour_step (alm_hour_step),
        .alm_min_step  (alm_min_step),
        .mode          (mode),
        .blink         (blink)
    );

    initial forever #5 Clk = ~Clk;

    // ---------------- behavioural reference model ----------------
    // Index 0 = MODE button, 1 = INC button.
    int  m_presc, m_mode, m_idle, m_cyc, m_next_rep;
    bit  m_rep_on;
    bit  m_d1[2], m_d2[2], m_acc[2], m_press[2];
    int  m_run[2];
    bit  e_sec_tick, e_clr_n, e_blink;
    bit  [3:0] e_step;

    task automatic model_reset();
        m_presc = 0; m_mode = 0; m_idle = 0; m_cyc = 0; m_next_rep = 0; m_rep_on = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_d1[i] = 1'b0; m_d2[i] = 1'b0; m_acc[i] = 1'b0; m_press[i] = 1'b0; m_run[i] = 0;
        end
        e_sec_tick = 1'b0; e_clr_n = 1'b1; e_blink = 1'b0; e_step = 4'b0;
    endtask

    // Called on each active edge: computes what the outputs must be during
    // the following cycle from what was visible during the previous one.
    task automatic model_step();
        int presc_prev, new_mode;
        bit tick, set_m, pm, pi, fire;
        bit raw[2];
        presc_prev = m_presc;
        tick  = (presc_prev == CLK_HZ - 1);
        set_m = (m_mode != 0);
        pm    = m_press[0];
        pi    = m_press[1];
        fire  = 1'b0;
        e_sec_tick = tick && !set_m;
        e_blink    = set_m && (presc_prev < CLK_HZ / 2);

        if (set_m && !pm && pi) begin
            fire = 1'b1; m_rep_on = 1'b1; m_next_rep = m_cyc + REP_DLY;
        end else if (set_m && !pm && m_rep_on && m_acc[1] && m_cyc == m_next_rep) begin
            fire = 1'b1; m_next_rep = m_cyc + REP_PER;
        end else if (pm || !m_acc[1] || !set_m) begin
            m_rep_on = 1'b0;
        end
        e_step = 4'b0;
        if (fire) e_step[m_mode - 1] = 1'b1;

        new_mode = m_mode;
        if (pm) begin
            new_mode = (m_mode + 1) % 5; m_idle = 0;
        end else if (!set_m || pi) begin
            m_idle = 0;
        end else if (tick) begin
            m_idle++;
            if (m_idle == TIMEOUT_S) begin new_mode = 0; m_idle = 0; end
        end
        e_clr_n = !(m_mode == 1 && new_mode == 2);
        m_mode  = new_mode;
        m_presc = (presc_prev + 1) % CLK_HZ;
        m_cyc++;

        raw[0] = btn_mode; raw[1] = btn_inc;
        for (int i = 0; i < 2; i++) begin
            m_press[i] = 1'b0;
            if (m_d2[i] != m_acc[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB_CYC) begin
                    m_acc[i] = ~m_acc[i]; m_run[i] = 0; m_press[i] = m_acc[i];
                end
            end else begin
                m_run[i] = 0;
            end
            m_d2[i] = m_d1[i];
            m_d1[i] = raw[i];
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge Clk or posedge Clr);
            if (Clr) model_reset();
            else model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    function automatic logic [9:0] outs();
        return {sec_tick, sec_clr_n, hour_step, min_step, alm_hour_step, alm_min_step, mode, blink};
    endfunction

    logic [9:0] cmp_act, cmp_exp;
    initial forever begin
        @(negedge Clk);
        if (chk_en) begin
            vectors++;
            cmp_act = outs();
            cmp_exp = {e_sec_tick, e_clr_n, e_step[0], e_step[1], e_step[2], e_step[3], 3'(m_mode), e_blink};
            if (cmp_act !== cmp_exp) begin
                errors++;
                $display("FAIL cycle_cmp at %0t: got %b required %b", $time, cmp_act, cmp_exp);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    logic [63:0] rec_hr, rec_min, rec_clr, rec_tick, rec_other;

    task automatic cyc(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // Raise the requested buttons at t=0, hold them hm/hi cycles, and record
    // the cycles on which each strobe is active for len cycles.
    task automatic window(input int hm, input int hi, input int len);
        rec_hr = '0; rec_min = '0; rec_clr = '0; rec_tick = '0; rec_other = '0;
        @(negedge Clk);
        btn_mode = (hm > 0);
        btn_inc  = (hi > 0);
        for (int t = 0; t < len; t++) begin
            if (t > 0) @(negedge Clk);
            if (t == hm) btn_mode = 1'b0;
            if (t == hi) btn_inc = 1'b0;
            rec_hr[t]    = hour_step;
            rec_min[t]   = min_step;
            rec_clr[t]   = ~sec_clr_n;
            rec_tick[t]  = sec_tick;
            rec_other[t] = alm_hour_step | alm_min_step;
        end
    endtask

    task automatic mode_pulse();
        @(negedge Clk);
        btn_mode = 1'b1;
        cyc(6);
        btn_mode = 1'b0;
        cyc(8);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int  k;
        bit  found;
        int  hm_left, hi_left, clr_left;

        cyc(3);
        chk_en = 1'b1;
        check("reset_outputs", 64'(outs()), 64'({1'b0, 1'b1, 4'b0, 3'd0, 1'b0}));

        // idle after reset: seconds tick every CLK_HZ cycles, nothing else
        Clr = 1'b0;
        rec_tick = '0; rec_other = '0;
        for (int t = 1; t <= 48; t++) begin
            @(negedge Clk);
            rec_tick[t]  = sec_tick;
            rec_other[t] = blink | (mode != 3'd0) | hour_step | min_step;
        end
        check("idle_tick_times", rec_tick, 64'h0001_0001_0001_0000);
        check("idle_blink_mode", rec_other, 64'h0);

        // MODE held 6 cycles enters SET_HR; seconds tick suppressed
        window(6, 0, 24);
        check("enter_set_hr", 64'(mode), 64'd1);
        check("set_hr_no_tick", rec_tick & ~64'h1F, 64'h0);

        // INC press in SET_HR: single hour step 5 cycles after the raw rise
        window(0, 6, 20);
        check("hour_step_times", rec_hr, 64'h20);
        check("hour_only", rec_min | rec_other, 64'h0);

        // SET_HR -> SET_MIN clears seconds for exactly one cycle
        window(6, 0, 14);
        check("sec_clr_times", rec_clr, 64'h20);
        check("enter_set_min", 64'(mode), 64'd2);

        // INC held 20 cycles: first step, then REP_DLY, then REP_PER spacing
        window(0, 20, 32);
        check("min_repeat_times", rec_min, 64'h0022_2020);
        check("min_only", rec_hr | rec_other, 64'h0);
        cyc(4);

        mode_pulse(); check("mode_ahr", 64'(mode), 64'd3);
        mode_pulse(); check("mode_amin", 64'(mode), 64'd4);
        mode_pulse(); check("mode_run", 64'(mode), 64'd0);
        mode_pulse(); check("mode_hr_again", 64'(mode), 64'd1);

        // no presses in SET_HR: forced back to RUN, then ticks resume
        k = 0;
        while (k < 80 && mode != 3'd0) begin @(negedge Clk); k++; end
        check("timeout_to_run", 64'(mode), 64'd0);
        found = 1'b0;
        k = 0;
        while (k < 20 && !found) begin @(negedge Clk); found = sec_tick; k++; end
        check("tick_after_timeout", 64'(found), 64'd1);

        // MODE and INC together in SET_HR: mode advances, INC dropped
        mode_pulse(); check("mode_hr_third", 64'(mode), 64'd1);
        window(6, 6, 20);
        check("mode_inc_together_mode", 64'(mode), 64'd2);
        check("mode_inc_together_steps", rec_hr | rec_min | rec_other, 64'h0);

        // reset in the middle of an INC auto-repeat
        @(negedge Clk);
        btn_inc = 1'b1;
        cyc(15);
        @(posedge Clk);
        #1 Clr = 1'b1;
        #1 check("reset_mid_repeat", 64'(outs()), 64'({1'b0, 1'b1, 4'b0, 3'd0, 1'b0}));
        @(negedge Clk);
        btn_inc = 1'b0;
        cyc(2);
        Clr = 1'b0;
        window(0, 0, 30);
        check("no_step_after_reset", rec_hr | rec_min | rec_other, 64'h0);

        // randomized buttons (including sub-debounce glitches) and rare resets
        hm_left = 0; hi_left = 0; clr_left = 0;
        for (int n = 0; n < 4000; n++) begin
            @(negedge Clk);
            if (hm_left == 0) begin
                btn_mode = ($urandom_range(0, 3) == 0);
                hm_left  = btn_mode ? int'($urandom_range(1, 8)) : int'($urandom_range(1, 70));
            end else begin
                hm_left--;
            end
            if (hi_left == 0) begin
                btn_inc = $urandom_range(0, 1) == 1;
                hi_left = int'($urandom_range(1, 30));
            end else begin
                hi_left--;
            end
            if (clr_left > 0) begin
                clr_left--;
                if (clr_left == 0) Clr = 1'b0;
            end else if ($urandom_range(0, 999) == 0) begin
                Clr = 1'b1;
                clr_left = 2;
            end
        end
        @(negedge Clk);
        Clr = 1'b0;
        cyc(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
